// File: rtl/key_event_pkg.sv
// Shared state encodings and width helper for the key event controller.
package key_event_pkg;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;

  localparam logic [1:0] K_WAIT  = 2'b00;
  localparam logic [1:0] K_IDLE  = 2'b01;
  localparam logic [1:0] K_PRESS = 2'b10;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_press_classifier.sv
// Classifies one debounced key into 1-cycle short/long press events.
// Latency: event registered one edge after key_q samples the release / final ms tick.
module key_press_classifier
  import key_event_pkg::*;
#(
  parameter int LONG_MS     = 1000,
  parameter bit KEY_ACT_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic key_in,
  output logic short_p,
  output logic long_p
);

  localparam int   HW         = cnt_width(LONG_MS);
  localparam logic KEY_ACTIVE = ~KEY_ACT_LOW;

  logic          key_q;
  logic          key_qq;
  logic [1:0]    state_q;
  logic [HW-1:0] hold_cnt;
  logic          pressed_q;
  logic          pressed_qq;

  assign pressed_q  = (key_q == KEY_ACTIVE);
  assign pressed_qq = (key_qq == KEY_ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      // Samples restart at the pressed level so a key held through reset never forms a press edge.
      key_q    <= KEY_ACTIVE;
      key_qq   <= KEY_ACTIVE;
      state_q  <= K_WAIT;
      hold_cnt <= '0;
      short_p  <= 1'b0;
      long_p   <= 1'b0;
    end else begin
      key_q   <= key_in;
      key_qq  <= key_q;
      short_p <= 1'b0;
      long_p  <= 1'b0;
      case (state_q)
        K_WAIT: begin
          if (!pressed_q) state_q <= K_IDLE;
        end
        K_IDLE: begin
          if (pressed_q && !pressed_qq) begin
            state_q  <= K_PRESS;
            hold_cnt <= '0;
          end
        end
        K_PRESS: begin
          if (!pressed_q) begin
            short_p <= 1'b1;
            state_q <= K_IDLE;
          end else if (ms_tick) begin
            if (hold_cnt >= HW'(LONG_MS - 1)) begin
              long_p   <= 1'b1;
              hold_cnt <= HW'(LONG_MS);
              state_q  <= K_WAIT;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
        end
        default: state_q <= K_WAIT;
      endcase
    end
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Turns Clear / start_stop key levels into stopwatch run/clear/lap control.
// Latency: outputs registered two edges after key_q samples the deciding key level.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int CLK_FREQ    = 10000000,
  parameter int LONG_MS     = 1000,
  parameter bit KEY_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_key,
  input  logic       ss_key,
  output logic       run_en,
  output logic       clear_pulse,
  output logic       lap_pulse,
  output logic [1:0] run_state
);

  localparam int PRESC_DIV = CLK_FREQ / 1000;
  localparam int PW        = cnt_width(PRESC_DIV - 1);

  logic [PW-1:0] presc;
  logic          ms_tick;
  logic          clr_short;
  logic          clr_long;
  logic          ss_short;
  logic          ss_long;
  logic [1:0]    state_q;

  assign ms_tick   = (presc == PW'(PRESC_DIV - 1));
  assign run_state = state_q;

  always_ff @(posedge clk) begin
    if (rst || ms_tick) presc <= '0;
    else                presc <= presc + 1'b1;
  end

  key_press_classifier #(
    .LONG_MS     (LONG_MS),
    .KEY_ACT_LOW (KEY_ACT_LOW)
  ) u_clr_cls (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick),
    .key_in  (clear_key),
    .short_p (clr_short),
    .long_p  (clr_long)
  );

  key_press_classifier #(
    .LONG_MS     (LONG_MS),
    .KEY_ACT_LOW (KEY_ACT_LOW)
  ) u_ss_cls (
    .clk     (clk),
    .rst     (rst),
    .ms_tick (ms_tick),
    .key_in  (ss_key),
    .short_p (ss_short),
    .long_p  (ss_long)
  );

  // Clear events win; an ss event in the same cycle only acts when the clear is ignored (RUN).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      run_en      <= 1'b0;
      clear_pulse <= 1'b0;
      lap_pulse   <= 1'b0;
    end else begin
      clear_pulse <= 1'b0;
      lap_pulse   <= 1'b0;
      case (state_q)
        S_IDLE, S_PAUSE: begin
          if (clr_long || clr_short) begin
            state_q     <= S_IDLE;
            run_en      <= 1'b0;
            clear_pulse <= 1'b1;
          end else if (ss_short) begin
            state_q <= S_RUN;
            run_en  <= 1'b1;
          end
        end
        S_RUN: begin
          if (clr_long) begin
            state_q     <= S_IDLE;
            run_en      <= 1'b0;
            clear_pulse <= 1'b1;
          end else if (ss_short) begin
            state_q <= S_PAUSE;
            run_en  <= 1'b0;
          end else if (ss_long) begin
            lap_pulse <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          run_en  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed + random bench for key_event_ctrl against an event-level stopwatch model.
module tb_key_event_ctrl;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear_key = 1'b1;
  logic       ss_key = 1'b1;
  logic       run_en;
  logic       clear_pulse;
  logic       lap_pulse;
  logic [1:0] run_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int clr_cnt = 0;
  int lap_cnt = 0;
  int lap_last = 0;

  logic [1:0] m_state = ST_IDLE;
  int exp_clr = 0;
  int exp_lap = 0;

  key_event_ctrl #(
    .CLK_FREQ    (10000),
    .LONG_MS     (5),
    .KEY_ACT_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_key   (clear_key),
    .ss_key      (ss_key),
    .run_en      (run_en),
    .clear_pulse (clear_pulse),
    .lap_pulse   (lap_pulse),
    .run_state   (run_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (clear_pulse) clr_cnt <= clr_cnt + 1;
    if (lap_pulse) begin
      lap_cnt  <= lap_cnt + 1;
      lap_last <= cyc;
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_state"}, run_state, m_state);
    check({tag, "_run_en"}, run_en, (m_state == ST_RUN));
    check({tag, "_clears"}, clr_cnt, exp_clr);
    check({tag, "_laps"}, lap_cnt, exp_lap);
  endtask

  // Stopwatch rules for one classified key event.
  task automatic model_event(input bit is_clr, input bit is_long);
    if (is_clr) begin
      if (is_long || m_state != ST_RUN) begin
        m_state = ST_IDLE;
        exp_clr++;
      end
    end else if (!is_long) begin
      m_state = (m_state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end else if (m_state == ST_RUN) begin
      exp_lap++;
    end
  endtask

  // Simultaneous clear + ss events: the ss event survives only if the clear is ignored.
  task automatic model_pair(input bit clr_long, input bit ss_long);
    if (clr_long || m_state != ST_RUN) model_event(1'b1, clr_long);
    else                               model_event(1'b0, ss_long);
  endtask

  task automatic press(input bit is_clr, input int dur);
    if (is_clr) clear_key = 1'b0;
    else        ss_key = 1'b0;
    ticks(dur);
    if (is_clr) clear_key = 1'b1;
    else        ss_key = 1'b1;
  endtask

  initial begin
    int ps;
    int dly;
    int kind;
    int dur;
    bit is_clr;
    bit is_long;

    // Reset values
    ticks(3);
    check("rst_state", run_state, ST_IDLE);
    check("rst_run_en", run_en, 0);
    check("rst_clear", clear_pulse, 0);
    check("rst_lap", lap_pulse, 0);
    rst = 1'b0;
    ticks(5);

    // 1: short ss press, exact two-edge latency after release sample
    ss_key = 1'b0;
    ticks(20);
    ss_key = 1'b1;
    ticks(2);
    check("t1_run_en_edge1", run_en, 0);
    ticks(1);
    check("t1_run_en_edge2", run_en, 1);
    check("t1_state_edge2", run_state, ST_RUN);
    model_event(1'b0, 1'b0);
    ticks(5);
    check_state("t1");

    // 2: long ss press in RUN gives one lap, no pause on release
    ps = cyc + 1;
    press(1'b0, 80);
    ticks(8);
    model_event(1'b0, 1'b1);
    check_state("t2");
    dly = lap_last - ps;
    check("t2_lap_window", (dly >= 41 && dly <= 52), 1);

    // 3: pause, then short clear gives a single-cycle clear pulse
    press(1'b0, 20);
    ticks(8);
    model_event(1'b0, 1'b0);
    check_state("t3_pause");
    clear_key = 1'b0;
    ticks(20);
    clear_key = 1'b1;
    ticks(2);
    check("t3_clr_edge1", clear_pulse, 0);
    ticks(1);
    check("t3_clr_edge2", clear_pulse, 1);
    check("t3_state_edge2", run_state, ST_IDLE);
    ticks(1);
    check("t3_clr_edge3", clear_pulse, 0);
    model_event(1'b1, 1'b0);
    ticks(5);
    check_state("t3_idle");
    press(1'b0, 20);
    ticks(8);
    model_event(1'b0, 1'b0);
    press(1'b1, 20);
    ticks(8);
    model_event(1'b1, 1'b0);
    check_state("t3_clr_in_run");

    // 4: simultaneous short releases, from RUN then from PAUSE
    clear_key = 1'b0;
    ss_key = 1'b0;
    ticks(20);
    clear_key = 1'b1;
    ss_key = 1'b1;
    ticks(8);
    model_pair(1'b0, 1'b0);
    check_state("t4_run_pair");
    clear_key = 1'b0;
    ss_key = 1'b0;
    ticks(15);
    clear_key = 1'b1;
    ss_key = 1'b1;
    ticks(8);
    model_pair(1'b0, 1'b0);
    check_state("t4_pause_pair");

    // 5: ss held through reset is ignored until released
    press(1'b0, 20);
    ticks(8);
    model_event(1'b0, 1'b0);
    check_state("t5_pre_run");
    ss_key = 1'b0;
    ticks(3);
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    m_state = ST_IDLE;
    ticks(100);
    check_state("t5_held");
    ss_key = 1'b1;
    ticks(8);
    check_state("t5_release");
    press(1'b0, 20);
    ticks(8);
    model_event(1'b0, 1'b0);
    check_state("t5_new_press");

    // 6: long clear in RUN, then illegal state recovery
    press(1'b1, 80);
    ticks(8);
    model_event(1'b1, 1'b1);
    check_state("t6_long_clr");
    press(1'b0, 20);
    ticks(8);
    model_event(1'b0, 1'b0);
    check_state("t6_rerun");
    force dut.state_q = 2'b11;
    #1;
    release dut.state_q;
    @(negedge clk);
    m_state = ST_IDLE;
    check_state("t6_illegal");

    // Random event sequence
    for (int i = 0; i < 16; i++) begin
      kind = $urandom_range(0, 4);
      if (kind == 0) begin
        dur = $urandom_range(12, 30);
        clear_key = 1'b0;
        ss_key = 1'b0;
        ticks(dur);
        clear_key = 1'b1;
        ss_key = 1'b1;
        ticks(8);
        model_pair(1'b0, 1'b0);
      end else begin
        is_clr  = ($urandom_range(0, 2) == 0);
        is_long = ($urandom_range(0, 2) == 0);
        dur = is_long ? $urandom_range(70, 89) : $urandom_range(12, 30);
        press(is_clr, dur);
        ticks(8);
        model_event(is_clr, is_long);
      end
      check_state($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
